disp_sched: RTL

DISP_SCHED -- requirements
Module: disp_sched

---
 rtl/disp_pkg.sv | 27 ++
 rtl/ledselect.sv | 22 ++
 rtl/disp_sched.sv | 135 +++++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// Shared types for the display scheduler: mode states, digit geometry
// and the press-driven mode step.
package disp_pkg;

    localparam int NUM_DIGITS = 6;
    localparam int DIGIT_W    = 5;

    typedef enum logic [1:0] {
        AUTO_A = 2'd0,
        AUTO_B = 2'd1,
        HOLD_A = 2'd2,
        HOLD_B = 2'd3
    } mode_e;

    function automatic logic page_of(mode_e m);
        return (m == AUTO_B) || (m == HOLD_B);
    endfunction

    function automatic mode_e press_next(mode_e m);
        case (m)
            HOLD_A:  return HOLD_B;
            HOLD_B:  return AUTO_A;
            default: return HOLD_A;
        endcase
    endfunction

endpackage

// File: rtl/ledselect.sv
// Page mux: maps the sum (page A) or contribution codes (page B)
// onto the six digit positions.
module ledselect
    import disp_pkg::*;
(
    input  logic                               i_sel,
    input  logic [15:0]                        i_val_a,
    input  logic [29:0]                        i_val_b,
    output logic [NUM_DIGITS-1:0][DIGIT_W-1:0] o_digits
);

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
        if (k < 4) begin : g_sum
            assign o_digits[k] = i_sel ? i_val_b[k*DIGIT_W +: DIGIT_W]
                                       : {1'b0, i_val_a[k*4 +: 4]};
        end else begin : g_blank
            assign o_digits[k] = i_sel ? i_val_b[k*DIGIT_W +: DIGIT_W]
                                       : '0;
        end
    end

endmodule

// File: rtl/disp_sched.sv
// Six-digit scan scheduler with debounced mode button and
// auto-alternating / held display pages.
module disp_sched
    import disp_pkg::*;
#(
    parameter int TICK_DIV       = 50000,
    parameter int DWELL_FRAMES   = 333,
    parameter int DEBOUNCE_TICKS = 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  btn,
    input  logic                  upd,
    input  logic [15:0]           val_a,
    input  logic [29:0]           val_b,
    output logic [DIGIT_W-1:0]    digit,
    output logic [NUM_DIGITS-1:0] dig_en,
    output logic                  sel,
    output logic                  mode_auto
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DWELL_FRAMES + 1);
    localparam int BW = $clog2(DEBOUNCE_TICKS + 1);

    localparam logic [PW-1:0] PRE_MAX   = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL_FRAMES - 1);
    localparam logic [BW-1:0] DEB_MAX   = BW'(DEBOUNCE_TICKS - 1);
    localparam logic [2:0]    IDX_LAST  = 3'(NUM_DIGITS - 1);

    logic [PW-1:0]      r_pre;
    logic [1:0]         r_sync;
    logic               r_db;
    logic [BW-1:0]      r_db_cnt;
    mode_e              r_state;
    logic [DW-1:0]      r_dwell;
    logic [2:0]         r_idx;
    logic               r_sel;
    logic [15:0]        r_sh_a;
    logic [29:0]        r_sh_b;
    logic [DIGIT_W-1:0] r_digit;
    logic [NUM_DIGITS-1:0] r_dig_en;

    logic               w_tick;
    logic               w_wrap;
    logic [2:0]         w_idx_nxt;
    logic               w_press;
    logic               w_auto;
    logic               w_expire;
    mode_e              w_state_nxt;
    logic [DW-1:0]      w_dwell_nxt;
    logic               w_sel_nxt;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0] w_digits;

    assign w_tick    = (r_pre == PRE_MAX);
    assign w_wrap    = w_tick && (r_idx == IDX_LAST);
    assign w_idx_nxt = (r_idx == IDX_LAST) ? 3'd0 : r_idx + 3'd1;
    assign w_press   = w_tick && !r_db && r_sync[1]
                    && (r_db_cnt == DEB_MAX);
    assign w_auto    = (r_state == AUTO_A) || (r_state == AUTO_B);
    assign w_expire  = w_wrap && w_auto && (r_dwell == DWELL_MAX);

    // A press outranks a coincident dwell expiry.
    always_comb begin
        w_state_nxt = r_state;
        w_dwell_nxt = r_dwell;
        if (w_press) begin
            w_state_nxt = press_next(r_state);
            w_dwell_nxt = '0;
        end else if (w_expire) begin
            w_state_nxt = (r_state == AUTO_A) ? AUTO_B : AUTO_A;
            w_dwell_nxt = '0;
        end else if (w_wrap && w_auto) begin
            w_dwell_nxt = r_dwell + 1'b1;
        end
    end

    // Page only switches at the frame boundary.
    assign w_sel_nxt = w_wrap ? page_of(w_state_nxt) : r_sel;

    ledselect u_ledsel (
        .i_sel    (w_sel_nxt),
        .i_val_a  (r_sh_a),
        .i_val_b  (r_sh_b),
        .o_digits (w_digits)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre    <= '0;
            r_sync   <= '0;
            r_db     <= 1'b0;
            r_db_cnt <= '0;
            r_state  <= AUTO_A;
            r_dwell  <= '0;
            r_idx    <= IDX_LAST;
            r_sel    <= 1'b0;
            r_sh_a   <= '0;
            r_sh_b   <= '0;
            r_digit  <= '0;
            r_dig_en <= '0;
        end else begin
            r_pre   <= w_tick ? '0 : r_pre + 1'b1;
            r_sync  <= {r_sync[0], btn};
            r_state <= w_state_nxt;
            r_dwell <= w_dwell_nxt;
            if (w_tick) begin
                if (r_sync[1] != r_db) begin
                    if (r_db_cnt == DEB_MAX) begin
                        r_db     <= ~r_db;
                        r_db_cnt <= '0;
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end
                end else begin
                    r_db_cnt <= '0;
                end
                r_idx    <= w_idx_nxt;
                r_sel    <= w_sel_nxt;
                r_digit  <= w_digits[w_idx_nxt];
                r_dig_en <= NUM_DIGITS'(1) << w_idx_nxt;
            end
            if (upd) begin
                r_sh_a <= val_a;
                r_sh_b <= val_b;
            end
        end
    end

    assign digit     = r_digit;
    assign dig_en    = r_dig_en;
    assign sel       = r_sel;
    assign mode_auto = w_auto;

endmodule
